// File: rtl/tdc_pkg.sv
// Shared types and sizing helpers for the TDC start/stop pulse generator.
package tdc_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DELAY = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4,
    DONE  = 3'd5
  } tdc_state_e;

  localparam int DW_DEF       = 8;
  localparam int RW_DEF       = 8;
  localparam int HOLD_CYC_DEF = 4;
  localparam int GAP_CYC_DEF  = 16;

  // Timer must hold any delay value as well as the hold and gap lengths.
  function automatic int tmr_width(input int dw, input int hold_cyc, input int gap_cyc);
    int m;
    m = 1 << dw;
    if (hold_cyc > m) m = hold_cyc;
    if (gap_cyc > m) m = gap_cyc;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/tdc_pulse_gen_if.sv
// Configuration handshake between the register front end and the generator.
interface tdc_pulse_gen_if #(
  parameter int DW = 8,
  parameter int RW = 8
);
  logic          cfg_valid;
  logic          cfg_ready;
  logic [DW-1:0] cfg_delay;
  logic [DW-1:0] cfg_step;
  logic [RW-1:0] cfg_count;

  modport master (
    output cfg_valid, cfg_delay, cfg_step, cfg_count,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_delay, cfg_step, cfg_count,
    output cfg_ready
  );
endinterface

// File: rtl/tdc_cycle_timer.sv
// Loadable down-counter shared by the DELAY, HOLD and GAP phases.
module tdc_cycle_timer #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [TW-1:0] val_i,
  output logic          zero_o
);

  logic [TW-1:0] cnt_q, cnt_d;

  // Reload on phase entry, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) cnt_d = val_i;
    else if (cnt_q != '0) cnt_d = cnt_q - TW'(1);
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/tdc_pulse_gen.sv
// Start/stop edge generator for TDC calibration sweeps.
//
// state | meaning
// IDLE  | waiting for a configuration, cfg_ready high
// START | first cycle of a shot, start rises (stop too when delay is 0)
// DELAY | start high, waiting for the stop edge
// HOLD  | start and stop both high
// GAP   | both low between shots
// DONE  | one-cycle done pulse after the last shot
module tdc_pulse_gen
  import tdc_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int RW       = RW_DEF,
  parameter int HOLD_CYC = HOLD_CYC_DEF,
  parameter int GAP_CYC  = GAP_CYC_DEF
) (
  input  logic            clk,
  input  logic            rst,
  tdc_pulse_gen_if.slave  cfg,
  input  logic            abort,
  output logic            start_o,
  output logic            stop_o,
  output logic            shot_o,
  output logic [DW-1:0]   cur_delay,
  output logic            busy,
  output logic            done
);

  localparam int TW = tmr_width(DW, HOLD_CYC, GAP_CYC);

  tdc_state_e    state_q, state_d;
  logic [DW-1:0] dly_q, dly_d, step_q, step_d;
  logic [RW-1:0] rem_q, rem_d;
  logic          start_q, start_d, stop_q, stop_d, shot_q, shot_d;
  logic          done_q, done_d, busy_q, busy_d, ready_q, ready_d;
  logic          tmr_load, tmr_zero, accept;
  logic [TW-1:0] tmr_val;

  assign accept = cfg.cfg_valid & ready_q & ~abort;

  tdc_cycle_timer #(.TW(TW)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i (tmr_load),
    .val_i  (tmr_val),
    .zero_o (tmr_zero)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and timer reload; a zero delay folds the START cycle into HOLD.
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (accept) state_d = (cfg.cfg_count == '0) ? DONE : START;
        START: begin
          tmr_load = 1'b1;
          if (dly_q == '0) begin
            if (HOLD_CYC == 1) begin
              state_d = GAP;
              tmr_val = TW'(GAP_CYC - 1);
            end else begin
              state_d = HOLD;
              tmr_val = TW'((HOLD_CYC > 1) ? HOLD_CYC - 2 : 0);
            end
          end else if (dly_q == DW'(1)) begin
            state_d = HOLD;
            tmr_val = TW'(HOLD_CYC - 1);
          end else begin
            state_d = DELAY;
            tmr_val = TW'(dly_q) - TW'(2);
          end
        end
        DELAY: if (tmr_zero) begin
          state_d  = HOLD;
          tmr_load = 1'b1;
          tmr_val  = TW'(HOLD_CYC - 1);
        end
        HOLD: if (tmr_zero) begin
          state_d  = GAP;
          tmr_load = 1'b1;
          tmr_val  = TW'(GAP_CYC - 1);
        end
        GAP:     if (tmr_zero) state_d = (rem_q == '0) ? DONE : START;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs and sweep datapath, decoded from the next state so they register alongside it.
  always_comb begin
    dly_d  = dly_q;
    step_d = step_q;
    rem_d  = rem_q;
    if (accept) begin
      dly_d  = cfg.cfg_delay;
      step_d = cfg.cfg_step;
      rem_d  = cfg.cfg_count;
    end else if (state_q == GAP && state_d == START) begin
      dly_d = dly_q + step_q;
    end
    start_d = (state_d inside {START, DELAY, HOLD});
    stop_d  = (state_d == HOLD) || (state_d == START && dly_d == '0);
    shot_d  = stop_d & ~stop_q;
    if (shot_d) rem_d = rem_d - RW'(1);
    done_d  = (state_d == DONE);
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
  end

  // Output and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      dly_q   <= '0;
      step_q  <= '0;
      rem_q   <= '0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      shot_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      dly_q   <= dly_d;
      step_q  <= step_d;
      rem_q   <= rem_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      shot_q  <= shot_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  assign start_o       = start_q;
  assign stop_o        = stop_q;
  assign shot_o        = shot_q;
  assign done          = done_q;
  assign busy          = busy_q;
  assign cur_delay     = dly_q;
  assign cfg.cfg_ready = ready_q;

endmodule
